// File: rtl/ball_array_move.sv
// Time-multiplexed trajectory engine: one ball slot is stepped per clock during a pass,
// with gravity, wall/ceiling reflection and a fixed-apex floor bounce.
module ball_array_move #(
  parameter int unsigned NUM_BALLS = 4,
  parameter int unsigned FRAC_BITS = 6,
  parameter int unsigned SPEED_W   = 16,
  parameter int unsigned GRAVITY   = 1,
  parameter int unsigned X_MAX     = 639,
  parameter int unsigned Y_MAX     = 479
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic                        spawn_valid,
  output logic                        spawn_ready,
  input  logic [10:0]                 spawn_x,
  input  logic [10:0]                 spawn_y,
  input  logic signed [SPEED_W-1:0]   spawn_xspeed,
  input  logic signed [SPEED_W-1:0]   spawn_yspeed,
  input  logic [SPEED_W-1:0]          spawn_bounce,
  input  logic [NUM_BALLS-1:0]        kill,
  output logic [11*NUM_BALLS-1:0]     topLeftX,
  output logic [11*NUM_BALLS-1:0]     topLeftY,
  output logic [NUM_BALLS-1:0]        active,
  output logic                        busy,
  output logic                        updateDone
);

  localparam int unsigned PW = 12 + FRAC_BITS;
  localparam int unsigned SW = ((PW > SPEED_W) ? PW : SPEED_W) + 2;
  localparam int unsigned IW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

  localparam logic [PW-1:0]        XMAX_P   = PW'(X_MAX << FRAC_BITS);
  localparam logic [PW-1:0]        YMAX_P   = PW'(Y_MAX << FRAC_BITS);
  localparam logic signed [SW-1:0] XMAX_S   = SW'(X_MAX << FRAC_BITS);
  localparam logic signed [SW-1:0] YMAX_S   = SW'(Y_MAX << FRAC_BITS);
  localparam logic [IW-1:0]        LAST_IDX = IW'(NUM_BALLS - 1);

  typedef enum logic {IDLE, UPDATE} state_t;

  typedef struct packed {
    logic signed [PW-1:0]      px;
    logic signed [PW-1:0]      py;
    logic signed [SPEED_W-1:0] vx;
    logic signed [SPEED_W-1:0] vy;
    logic [SPEED_W-1:0]        bounce;
  } slot_t;

  state_t                state_q;
  logic [IW-1:0]         idx_q;
  logic                  pending_q;
  logic                  spawn_ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic [NUM_BALLS-1:0]  active_q;
  logic [NUM_BALLS-1:0]  active_d;
  slot_t                 slot_q [NUM_BALLS];

  slot_t                 cur_slot;
  slot_t                 step_slot;
  slot_t                 spawn_slot;
  logic signed [SW-1:0]  nx;
  logic signed [SW-1:0]  ny;
  logic [IW-1:0]         free_idx;
  logic                  spawn_fire;
  logic                  updating;
  logic [NUM_BALLS-1:0]  wr_spawn;
  logic [NUM_BALLS-1:0]  wr_step;

  // One-ball step of the slot currently addressed by idx_q
  always_comb begin
    cur_slot  = slot_q[idx_q];
    step_slot = cur_slot;
    nx = {{(SW-PW){cur_slot.px[PW-1]}}, cur_slot.px}
       + {{(SW-SPEED_W){cur_slot.vx[SPEED_W-1]}}, cur_slot.vx};
    ny = {{(SW-PW){cur_slot.py[PW-1]}}, cur_slot.py}
       + {{(SW-SPEED_W){cur_slot.vy[SPEED_W-1]}}, cur_slot.vy};

    if (nx[SW-1]) begin
      step_slot.px = '0;
      step_slot.vx = -cur_slot.vx;
    end else if (nx > XMAX_S) begin
      step_slot.px = XMAX_P;
      step_slot.vx = -cur_slot.vx;
    end else begin
      step_slot.px = nx[PW-1:0];
    end

    // Floor bounce uses the per-ball fixed speed so the apex height never decays
    if (ny[SW-1]) begin
      step_slot.py = '0;
      step_slot.vy = -cur_slot.vy;
    end else if ((ny >= YMAX_S) && !cur_slot.vy[SPEED_W-1] && (|cur_slot.vy)) begin
      step_slot.py = YMAX_P;
      step_slot.vy = -cur_slot.bounce;
    end else begin
      step_slot.py = ny[PW-1:0];
      step_slot.vy = cur_slot.vy + SPEED_W'(GRAVITY);
    end
  end

  // Spawn payload and lowest free slot
  always_comb begin
    spawn_slot.px     = PW'({spawn_x, {FRAC_BITS{1'b0}}});
    spawn_slot.py     = PW'({spawn_y, {FRAC_BITS{1'b0}}});
    spawn_slot.vx     = spawn_xspeed;
    spawn_slot.vy     = spawn_yspeed;
    spawn_slot.bounce = spawn_bounce;
    free_idx = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (!active_q[i]) free_idx = IW'(i);
    end
  end

  // Per-slot write enables; kill suppresses a step on the same slot
  always_comb begin
    spawn_fire = spawn_valid && spawn_ready_q;
    updating   = (state_q == UPDATE);
    wr_spawn   = '0;
    wr_step    = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      wr_spawn[i] = spawn_fire && (free_idx == IW'(i));
      wr_step[i]  = updating && (idx_q == IW'(i)) && active_q[i] && !kill[i];
    end
    active_d = (active_q & ~kill) | wr_spawn;
  end

  // Pass sequencer with registered status outputs
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      pending_q     <= 1'b0;
      spawn_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      active_q      <= '0;
    end else begin
      active_q <= active_d;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          idx_q     <= '0;
          pending_q <= 1'b0;
          if (startOfFrame) begin
            state_q       <= UPDATE;
            busy_q        <= 1'b1;
            spawn_ready_q <= 1'b0;
          end else begin
            spawn_ready_q <= ~&active_d;
          end
        end
        UPDATE: begin
          if (idx_q == LAST_IDX) begin
            done_q    <= 1'b1;
            idx_q     <= '0;
            pending_q <= 1'b0;
            if (pending_q || startOfFrame) begin
              spawn_ready_q <= 1'b0;
            end else begin
              state_q       <= IDLE;
              busy_q        <= 1'b0;
              spawn_ready_q <= ~&active_d;
            end
          end else begin
            idx_q         <= idx_q + IW'(1);
            spawn_ready_q <= 1'b0;
            if (startOfFrame) pending_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Slot state storage
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_BALLS; i++) slot_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BALLS; i++) begin
        if (wr_spawn[i])     slot_q[i] <= spawn_slot;
        else if (wr_step[i]) slot_q[i] <= step_slot;
      end
    end
  end

  always_comb begin
    topLeftX = '0;
    topLeftY = '0;
    for (int i = 0; i < NUM_BALLS; i++) begin
      topLeftX[11*i +: 11] = slot_q[i].px[FRAC_BITS +: 11];
      topLeftY[11*i +: 11] = slot_q[i].py[FRAC_BITS +: 11];
    end
  end

  assign spawn_ready = spawn_ready_q;
  assign active      = active_q;
  assign busy        = busy_q;
  assign updateDone  = done_q;

endmodule

// File: tb/tb_ball_array_move.sv
// Directed bench for ball_array_move: single-ball trajectory table plus pass timing,
// slot allocation, kill and back-to-back frame sequences.
module tb_ball_array_move;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               spawn_valid;
  logic               spawn_ready;
  logic [10:0]        spawn_x;
  logic [10:0]        spawn_y;
  logic signed [15:0] spawn_xspeed;
  logic signed [15:0] spawn_yspeed;
  logic [15:0]        spawn_bounce;
  logic [3:0]         kill;
  logic [43:0]        topLeftX;
  logic [43:0]        topLeftY;
  logic [3:0]         active;
  logic               busy;
  logic               updateDone;

  ball_array_move dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .spawn_valid  (spawn_valid),
    .spawn_ready  (spawn_ready),
    .spawn_x      (spawn_x),
    .spawn_y      (spawn_y),
    .spawn_xspeed (spawn_xspeed),
    .spawn_yspeed (spawn_yspeed),
    .spawn_bounce (spawn_bounce),
    .kill         (kill),
    .topLeftX     (topLeftX),
    .topLeftY     (topLeftY),
    .active       (active),
    .busy         (busy),
    .updateDone   (updateDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int vx;
    int vy;
    int b;
    int frames;
    int ex;
    int ey;
  } vec_t;

  vec_t vecs [11];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_spawn(input int x, input int y, input int vx, input int vy, input int b);
    int t;
    t = 0;
    @(negedge clk);
    while (!spawn_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!spawn_ready) check("spawn_ready_timeout", 0, 1);
    spawn_x      = 11'(x);
    spawn_y      = 11'(y);
    spawn_xspeed = 16'(vx);
    spawn_yspeed = 16'(vy);
    spawn_bounce = 16'(b);
    spawn_valid  = 1'b1;
    @(negedge clk);
    spawn_valid  = 1'b0;
  endtask

  task automatic do_frame(output int lat);
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    lat = 0;
    while (!updateDone && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!updateDone) check("frame_timeout", 0, 1);
  endtask

  task automatic kill_all();
    @(negedge clk);
    kill = 4'hF;
    @(negedge clk);
    kill = 4'h0;
  endtask

  initial begin
    int          lat;
    int          busy_cnt;
    int          done_cnt;
    int          rdy_cnt;
    logic [43:0] expx;
    logic [43:0] expy;

    //            x     y    vx   vy    b  fr   ex   ey
    vecs[0]  = '{100,   50,  64,   0,   0, 1, 101,  50};
    vecs[1]  = '{639,  100,  64,   0,   0, 1, 639, 100};
    vecs[2]  = '{639,  100,  64,   0,   0, 2, 638, 100};
    vecs[3]  = '{0,    100, -64,   0,   0, 1,   0, 100};
    vecs[4]  = '{0,    100, -64,   0,   0, 2,   1, 100};
    vecs[5]  = '{200,  479,   0,  32, 200, 1, 200, 479};
    vecs[6]  = '{200,  479,   0,  32, 200, 2, 200, 475};
    vecs[7]  = '{10,     0,   0, -64,   0, 2,  10,   1};
    vecs[8]  = '{2000, 479,   0,   0,   0, 1, 639, 479};
    vecs[9]  = '{300,  200,  32,   0,   0, 2, 301, 200};
    vecs[10] = '{50,   470,   0, 640, 100, 2,  50, 477};

    resetN       = 1'b0;
    startOfFrame = 1'b0;
    spawn_valid  = 1'b0;
    spawn_x      = '0;
    spawn_y      = '0;
    spawn_xspeed = '0;
    spawn_yspeed = '0;
    spawn_bounce = '0;
    kill         = '0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);

    check("rst_topLeftX", topLeftX, 0);
    check("rst_topLeftY", topLeftY, 0);
    check("rst_active", active, 0);
    check("rst_busy", busy, 0);
    check("rst_updateDone", updateDone, 0);
    check("rst_spawn_ready", spawn_ready, 1);

    // Pass timing: slot 0 visible after E1, done pulse after E4
    do_spawn(100, 50, 64, 0, 0);
    check("spawn_active", active, 1);
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    check("pass_busy_start", busy, 1);
    check("pass_x_before_write", topLeftX[10:0], 100);
    check("pass_ready_busy", spawn_ready, 0);
    @(negedge clk);
    check("pass_x_after_write", topLeftX[10:0], 101);
    for (int c = 3; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("pass_done_c%0d", c), updateDone, (c == 5) ? 1 : 0);
      check($sformatf("pass_busy_c%0d", c), busy, (c < 5) ? 1 : 0);
    end
    @(negedge clk);
    check("pass_done_clear", updateDone, 0);
    check("pass_y", topLeftY[10:0], 50);

    // Single-ball trajectory table
    for (int v = 0; v < 11; v++) begin
      kill_all();
      do_spawn(vecs[v].x, vecs[v].y, vecs[v].vx, vecs[v].vy, vecs[v].b);
      for (int f = 0; f < vecs[v].frames; f++) do_frame(lat);
      check($sformatf("vec%0d_x", v), topLeftX[10:0], vecs[v].ex);
      check($sformatf("vec%0d_y", v), topLeftY[10:0], vecs[v].ey);
    end

    // Fill all slots, kill one, refill goes to the freed slot
    kill_all();
    for (int i = 0; i < 4; i++) do_spawn(10 * (i + 1), 100, 64, 0, 0);
    check("fill_ready", spawn_ready, 0);
    check("fill_active", active, 4'hF);
    expx = {11'd40, 11'd30, 11'd20, 11'd10};
    check("fill_x", topLeftX, expx);
    @(negedge clk);
    kill = 4'b0100;
    @(negedge clk);
    kill = 4'b0000;
    check("kill2_ready", spawn_ready, 1);
    check("kill2_active", active, 4'b1011);
    do_spawn(500, 100, 64, 0, 0);
    check("respawn_active", active, 4'hF);
    expx = {11'd40, 11'd500, 11'd20, 11'd10};
    check("respawn_x", topLeftX, expx);

    // Kill slot 2 at the edge that steps it
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
    @(negedge clk);
    kill = 4'b0100;
    @(negedge clk);
    kill = 4'b0000;
    @(negedge clk);
    check("kstep_done", updateDone, 1);
    expx = {11'd41, 11'd500, 11'd21, 11'd11};
    check("kstep_x", topLeftX, expx);
    check("kstep_active", active, 4'b1011);
    check("kstep_ready", spawn_ready, 1);

    // startOfFrame during a pass queues one back-to-back pass
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    rdy_cnt  = 0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (busy) busy_cnt++;
      if (updateDone) done_cnt++;
      if (busy && spawn_ready) rdy_cnt++;
      startOfFrame = (c == 1);
    end
    check("b2b_busy_cycles", busy_cnt, 8);
    check("b2b_done_pulses", done_cnt, 2);
    check("b2b_ready_while_busy", rdy_cnt, 0);
    expx = {11'd43, 11'd500, 11'd23, 11'd13};
    expy = {11'd100, 11'd100, 11'd100, 11'd100};
    check("b2b_x", topLeftX, expx);
    check("b2b_y", topLeftY, expy);

    // Spawn accepted together with startOfFrame is stepped in that pass
    kill_all();
    @(negedge clk);
    spawn_x      = 11'd100;
    spawn_y      = 11'd50;
    spawn_xspeed = 16'sd64;
    spawn_yspeed = 16'sd0;
    spawn_bounce = 16'd0;
    spawn_valid  = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    spawn_valid  = 1'b0;
    startOfFrame = 1'b0;
    check("cospawn_busy", busy, 1);
    lat = 0;
    while (!updateDone && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("cospawn_latency", lat, 4);
    check("cospawn_x", topLeftX[10:0], 101);

    // Reset in the middle of a pass
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    @(negedge clk);
    resetN = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_active", active, 0);
    check("midrst_ready", spawn_ready, 1);
    check("midrst_x", topLeftX, 0);
    @(negedge clk);
    resetN = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (updateDone || busy) done_cnt++;
    end
    check("midrst_quiet", done_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
